rv_iommu_mmio_regs: RTL and testbench
=====================================

// Module: rv_iommu_mmio_regs
// PURPOSE
// - Parametrised APB MMIO register file for the IOMMU. It holds CAPABILITIES, FCTRL, DDTP, and the command-queue registers CQB, CQH/CQT and CQCSR.
// - It replaces the single-register DDTP slave. Additions over that slave: PREADY/PSLVERR, a shadowed DDTP handover to the page walker, and command-queue enable with pointer tracking.
// - It sits between the system APB fabric and the page walker / command-queue engine.
// PARAMETERS
// - ADDR_W  12  APB address width; byte offset = paddr[11:0], paddr[2:0] ignored (64-bit aligned only).
// - PPN_W   44  PPN width for DDTP.ppn and CQB.ppn (register bits [10+PPN_W-1:10]).
// - CQ_IDX_W  12  CQH/CQT index width. Legal CQB.log2sz-1 range is 0..CQ_IDX_W-1.
// - CAPS  64'h0  Read-only value returned at CAPABILITIES.
// PORTS
// - clk  in  1  Clock.
// - rst_n  in  1  Reset, asynchronous, active-low.
// - psel, penable, pwrite  in  1 each  APB control.
// - paddr  in  ADDR_W  APB address.
// - pwdata  in  64  Write data.
// - pstrb  in  8  Byte strobes; present only with IOMMU_MMIO_WSTRB_EN.
// - prdata  out  64  Read data.
// - pready  out  1  Access-phase ready.
// - pslverr  out  1  Access-phase error.
// - ddtp_mode_o  out  4  Shadow DDTP mode, as seen by the walker.
// - ddtp_ppn_o  out  PPN_W  Shadow DDTP ppn.
// - ddtp_stall_req_o  out  1  Walker stall request (= DDTP.busy).
// - ddtp_pgwk_idle_i  in  1  Walker idle/drained.
// - cq_ppn_o  out  PPN_W  CQB ppn.
// - cq_log2sz_o  out  5  CQB.log2sz-1.
// - cq_on_o  out  1  Command queue active.
// - cq_head_o, cq_tail_o  out  CQ_IDX_W  Head and tail indices.
// - cq_head_inc_i  in  1  Engine consumed one command.
// - cq_mf_i, cq_ill_i  in  1 each  Set CQCSR.cqmf / CQCSR.cmd_ill.
// BEHAVIOUR
// - Map (byte offset):
//   - 0x00 CAPS (RO).
//   - 0x08 FCTRL (RO 0).
//   - 0x10 DDTP: mode[3:0], busy[4] RO, ppn.
//   - 0x18 CQB: log2sz[4:0], ppn.
//   - 0x20 {CQT[63:32] RW, CQH[31:0] RO}.
//   - 0x48 CQCSR: cqen[0], cqmf[8] RW1C, cmd_ill[10] RW1C, cqon[16] RO, busy[17] RO.
//   - Unused register bits read 0.
// - APB: zero wait states; pready=1 whenever psel&penable.
//   - prdata is combinational in the access phase and 0 otherwise.
//   - Register updates land on the clk edge that ends the access phase.
// - Unmapped offset: pslverr=1 in the access phase, prdata=0, no state change.
// - DDTP write: accepted only if busy=0 and mode<=4 (Off/Bare/1LVL/2LVL/3LVL).
//   - Accepted: store mode/ppn, set busy. Otherwise silently ignored, pslverr=0.
// - DDTP handover: while busy=1 && ddtp_pgwk_idle_i=1, copy mode/ppn to the shadow and clear busy on that edge.
//   - Outputs follow the shadow only, never a half-written value.
// - CQB write: accepted only when cqon=0 and CQCSR.busy=0; otherwise ignored.
//   - log2sz values >= CQ_IDX_W are clamped to CQ_IDX_W-1.
// - CQT write: tail <= pwdata[32+:CQ_IDX_W] & (2^(log2sz+1)-1).
// - CQH is written by hardware only.
// - CQCSR.cqen written with a value != cqon sets CQCSR.busy for exactly 1 cycle; the next edge sets cqon=cqen.
//   - On enable: head and tail clear to 0, cqmf and cmd_ill clear.
// - cq_head_inc_i with cqon=1: head <= (head+1) & (2^(log2sz+1)-1), i.e. it wraps at queue size. Ignored when cqon=0.
// - cq_mf_i / cq_ill_i set their sticky bits. Set wins over a same-cycle RW1C clear.
// - Any cqmf or cmd_ill set forces cq_on_o=0 (engine stalls); cqon remains 1 so software sees it.
// - Reset values: every register and output is 0 (mode=Off, busy=0, cqon=0, head=tail=0); pready=pslverr=prdata=0.
// - Reset asserted mid-access: the access is dropped and all state returns to its reset value.
// CONFIGURATION
// - IOMMU_MMIO_WSTRB_EN defined: pstrb exists; each written register byte updates only when its pstrb bit is set.
//   - RW1C bits clear only under their strobe.
//   - A DDTP/CQB write needs pstrb[0]=1 to be accepted.
// - IOMMU_MMIO_WSTRB_EN undefined: no pstrb port; every write is a full 64-bit write.
// TESTING
// - Write DDTP=0x...0003 (mode 3, ppn 0x123) -> busy=1 and stall_req=1.
//   - Raise idle 2 cycles later -> shadow mode=3, ppn=0x123, busy=0 on that edge.
// - DDTP write with mode=5, or a second write while busy -> register and shadow unchanged, pslverr=0.
// - Read offset 0x30 -> pslverr=1, prdata=0. Read 0x00 -> CAPS.
// - CQB log2sz=2 (8 entries), cqen=1 -> CQCSR.busy for 1 cycle, then cqon=1.
//   - 9 head_inc pulses -> CQH=1 (wrap).
//   - CQT write 0xB -> CQT=3.
// - cq_ill_i pulse in the same cycle as a W1C of bit10 -> cmd_ill=1, cq_on_o=0.
//   - A later W1C -> cmd_ill=0, cq_on_o=1.
// - IOMMU_MMIO_WSTRB_EN: DDTP write with pstrb=8'h02 -> ignored; pstrb=8'hFF -> accepted.

Source files
------------

// File: rtl/rv_iommu_mmio_regs.sv
// Purpose: APB MMIO register file for the IOMMU. It holds CAPS, FCTRL, DDTP (with a shadow
//          copy for the walker), CQB, CQH/CQT and CQCSR.
// Latency: zero APB wait states. Read data is combinational in the access phase. Register
//          updates land on the clk edge that ends the access phase.
// Backpressure: none. pready is high for every access phase. Unmapped offsets return pslverr.
//
// Ports:
//   APB slave:    psel, penable, pwrite, paddr, pwdata, [pstrb], prdata, pready, pslverr
//   Walker:       ddtp_mode_o, ddtp_ppn_o (shadow copy), ddtp_stall_req_o, ddtp_pgwk_idle_i
//   CQ engine:    cq_ppn_o, cq_log2sz_o, cq_on_o, cq_head_o, cq_tail_o,
//                 cq_head_inc_i, cq_mf_i, cq_ill_i
// Build option:   IOMMU_MMIO_WSTRB_EN adds the pstrb port and enables per-byte write strobes.
//                 Without it, every write is a full 64-bit write.

module rv_iommu_mmio_regs #(
    parameter int          ADDR_W   = 12,
    parameter int          PPN_W    = 44,
    parameter int          CQ_IDX_W = 12,
    parameter logic [63:0] CAPS     = 64'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [63:0]         pwdata,
`ifdef IOMMU_MMIO_WSTRB_EN
    input  logic [7:0]          pstrb,
`endif
    output logic [63:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [3:0]          ddtp_mode_o,
    output logic [PPN_W-1:0]    ddtp_ppn_o,
    output logic                ddtp_stall_req_o,
    input  logic                ddtp_pgwk_idle_i,
    output logic [PPN_W-1:0]    cq_ppn_o,
    output logic [4:0]          cq_log2sz_o,
    output logic                cq_on_o,
    output logic [CQ_IDX_W-1:0] cq_head_o,
    output logic [CQ_IDX_W-1:0] cq_tail_o,
    input  logic                cq_head_inc_i,
    input  logic                cq_mf_i,
    input  logic                cq_ill_i
);

    localparam logic [8:0] OFS_CAPS  = 9'h000;   // 0x00
    localparam logic [8:0] OFS_FCTRL = 9'h001;   // 0x08
    localparam logic [8:0] OFS_DDTP  = 9'h002;   // 0x10
    localparam logic [8:0] OFS_CQB   = 9'h003;   // 0x18
    localparam logic [8:0] OFS_CQHT  = 9'h004;   // 0x20
    localparam logic [8:0] OFS_CQCSR = 9'h009;   // 0x48
    localparam logic [4:0] LOG2_MAX  = 5'(CQ_IDX_W - 1);

    // State
    logic [3:0]          ddtp_mode_q, ddtp_mode_d;
    logic [PPN_W-1:0]    ddtp_ppn_q,  ddtp_ppn_d;
    logic                ddtp_busy_q, ddtp_busy_d;
    logic [3:0]          sh_mode_q,   sh_mode_d;
    logic [PPN_W-1:0]    sh_ppn_q,    sh_ppn_d;
    logic [4:0]          cqb_log2_q,  cqb_log2_d;
    logic [PPN_W-1:0]    cqb_ppn_q,   cqb_ppn_d;
    logic [CQ_IDX_W-1:0] cq_head_q,   cq_head_d;
    logic [CQ_IDX_W-1:0] cq_tail_q,   cq_tail_d;
    logic                cqen_q,      cqen_d;
    logic                cqon_q,      cqon_d;
    logic                cq_busy_q,   cq_busy_d;
    logic                cqmf_q,      cqmf_d;
    logic                cmd_ill_q,   cmd_ill_d;

    // APB decode. Reset gates the access so that the APB outputs read 0 during reset.
    logic        access;
    logic        hit;
    logic [8:0]  ofs;
    logic [63:0] rdata;
    logic [63:0] wmask;
    logic        strb0;

    assign access = psel & penable & rst_n;
    assign ofs    = paddr[11:3];

`ifdef IOMMU_MMIO_WSTRB_EN
    always_comb begin
        wmask = '0;
        for (int i = 0; i < 8; i++) begin
            wmask[8*i +: 8] = {8{pstrb[i]}};
        end
    end
    assign strb0 = pstrb[0];
`else
    assign wmask = '1;
    assign strb0 = 1'b1;
`endif

    logic wr_ddtp, wr_cqb, wr_cqt, wr_cqcsr;
    assign wr_ddtp  = access & pwrite & (ofs == OFS_DDTP);
    assign wr_cqb   = access & pwrite & (ofs == OFS_CQB);
    assign wr_cqt   = access & pwrite & (ofs == OFS_CQHT);
    assign wr_cqcsr = access & pwrite & (ofs == OFS_CQCSR);

    // Byte-merged write values. Bytes without a strobe keep the current register contents.
    logic [3:0]          ddtp_mode_w;
    logic [PPN_W-1:0]    ddtp_ppn_w;
    logic [4:0]          cqb_log2_w;
    logic [PPN_W-1:0]    cqb_ppn_w;
    logic [CQ_IDX_W-1:0] cq_tail_w;
    logic                cqen_w, clr_mf, clr_ill;

    assign ddtp_mode_w = (ddtp_mode_q & ~wmask[3:0]) | (pwdata[3:0] & wmask[3:0]);
    assign ddtp_ppn_w  = (ddtp_ppn_q & ~wmask[10 +: PPN_W]) | (pwdata[10 +: PPN_W] & wmask[10 +: PPN_W]);
    assign cqb_log2_w  = (cqb_log2_q & ~wmask[4:0]) | (pwdata[4:0] & wmask[4:0]);
    assign cqb_ppn_w   = (cqb_ppn_q & ~wmask[10 +: PPN_W]) | (pwdata[10 +: PPN_W] & wmask[10 +: PPN_W]);
    assign cq_tail_w   = (cq_tail_q & ~wmask[32 +: CQ_IDX_W]) | (pwdata[32 +: CQ_IDX_W] & wmask[32 +: CQ_IDX_W]);
    assign cqen_w      = wmask[0] ? pwdata[0] : cqen_q;
    assign clr_mf      = pwdata[8]  & wmask[8];
    assign clr_ill     = pwdata[10] & wmask[10];

    // The index mask is 2^(log2sz+1)-1. log2sz is clamped on write, so the mask stays in range.
    logic [CQ_IDX_W-1:0] idx_mask;
    always_comb begin
        idx_mask = '0;
        for (int i = 0; i < CQ_IDX_W; i++) begin
            idx_mask[i] = (5'(i) <= cqb_log2_q);
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (ofs)
            OFS_CAPS:  rdata = CAPS;
            OFS_FCTRL: rdata = '0;
            OFS_DDTP: begin
                rdata[3:0]        = ddtp_mode_q;
                rdata[4]          = ddtp_busy_q;
                rdata[10 +: PPN_W] = ddtp_ppn_q;
            end
            OFS_CQB: begin
                rdata[4:0]        = cqb_log2_q;
                rdata[10 +: PPN_W] = cqb_ppn_q;
            end
            OFS_CQHT: begin
                rdata[0  +: CQ_IDX_W] = cq_head_q;
                rdata[32 +: CQ_IDX_W] = cq_tail_q;
            end
            OFS_CQCSR: begin
                rdata[0]  = cqen_q;
                rdata[8]  = cqmf_q;
                rdata[10] = cmd_ill_q;
                rdata[16] = cqon_q;
                rdata[17] = cq_busy_q;
            end
            default: hit = 1'b0;
        endcase
    end

    assign pready  = access;
    assign pslverr = access & ~hit;
    assign prdata  = (access & ~pwrite & hit) ? rdata : 64'h0;

    // Next-state logic
    always_comb begin
        ddtp_mode_d = ddtp_mode_q;
        ddtp_ppn_d  = ddtp_ppn_q;
        ddtp_busy_d = ddtp_busy_q;
        sh_mode_d   = sh_mode_q;
        sh_ppn_d    = sh_ppn_q;
        cqb_log2_d  = cqb_log2_q;
        cqb_ppn_d   = cqb_ppn_q;
        cq_head_d   = cq_head_q;
        cq_tail_d   = cq_tail_q;
        cqen_d      = cqen_q;
        cqon_d      = cqon_q;
        cq_busy_d   = 1'b0;
        cqmf_d      = cqmf_q;
        cmd_ill_d   = cmd_ill_q;

        // Handover to the walker. A write can only be accepted while busy=0, so the
        // handover and a write never collide.
        if (ddtp_busy_q && ddtp_pgwk_idle_i) begin
            sh_mode_d   = ddtp_mode_q;
            sh_ppn_d    = ddtp_ppn_q;
            ddtp_busy_d = 1'b0;
        end
        if (wr_ddtp && !ddtp_busy_q && strb0 && (ddtp_mode_w <= 4'd4)) begin
            ddtp_mode_d = ddtp_mode_w;
            ddtp_ppn_d  = ddtp_ppn_w;
            ddtp_busy_d = 1'b1;
        end

        if (wr_cqb && !cqon_q && !cq_busy_q && strb0) begin
            cqb_log2_d = (cqb_log2_w > LOG2_MAX) ? LOG2_MAX : cqb_log2_w;
            cqb_ppn_d  = cqb_ppn_w;
        end

        if (cqon_q && cq_head_inc_i) begin
            cq_head_d = (cq_head_q + CQ_IDX_W'(1)) & idx_mask;
        end
        if (wr_cqt) begin
            cq_tail_d = cq_tail_w & idx_mask;
        end

        if (wr_cqcsr && clr_mf)  cqmf_d    = 1'b0;
        if (wr_cqcsr && clr_ill) cmd_ill_d = 1'b0;

        // Enable/disable takes one busy cycle. The cqen changes made while busy are dropped.
        if (cq_busy_q) begin
            cqon_d = cqen_q;
            if (cqen_q) begin
                cq_head_d = '0;
                cq_tail_d = '0;
                cqmf_d    = 1'b0;
                cmd_ill_d = 1'b0;
            end
        end else if (wr_cqcsr && (cqen_w != cqon_q)) begin
            cqen_d    = cqen_w;
            cq_busy_d = 1'b1;
        end

        // The hardware set wins over any same-cycle clear.
        if (cq_mf_i)  cqmf_d    = 1'b1;
        if (cq_ill_i) cmd_ill_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddtp_mode_q <= '0;
            ddtp_ppn_q  <= '0;
            ddtp_busy_q <= 1'b0;
            sh_mode_q   <= '0;
            sh_ppn_q    <= '0;
            cqb_log2_q  <= '0;
            cqb_ppn_q   <= '0;
            cq_head_q   <= '0;
            cq_tail_q   <= '0;
            cqen_q      <= 1'b0;
            cqon_q      <= 1'b0;
            cq_busy_q   <= 1'b0;
            cqmf_q      <= 1'b0;
            cmd_ill_q   <= 1'b0;
        end else begin
            ddtp_mode_q <= ddtp_mode_d;
            ddtp_ppn_q  <= ddtp_ppn_d;
            ddtp_busy_q <= ddtp_busy_d;
            sh_mode_q   <= sh_mode_d;
            sh_ppn_q    <= sh_ppn_d;
            cqb_log2_q  <= cqb_log2_d;
            cqb_ppn_q   <= cqb_ppn_d;
            cq_head_q   <= cq_head_d;
            cq_tail_q   <= cq_tail_d;
            cqen_q      <= cqen_d;
            cqon_q      <= cqon_d;
            cq_busy_q   <= cq_busy_d;
            cqmf_q      <= cqmf_d;
            cmd_ill_q   <= cmd_ill_d;
        end
    end

    assign ddtp_mode_o      = sh_mode_q;
    assign ddtp_ppn_o       = sh_ppn_q;
    assign ddtp_stall_req_o = ddtp_busy_q;
    assign cq_ppn_o         = cqb_ppn_q;
    assign cq_log2sz_o      = cqb_log2_q;
    // A sticky fault stalls the engine. cqon stays visible to software.
    assign cq_on_o          = cqon_q & ~cqmf_q & ~cmd_ill_q;
    assign cq_head_o        = cq_head_q;
    assign cq_tail_o        = cq_tail_q;

    // Address bits below the 64-bit word, plus mask/data bits that no register field uses.
    logic unused_ok;
    assign unused_ok = ^{paddr, pwdata, wmask};

endmodule

// File: tb/tb_rv_iommu_mmio_regs.sv
module tb_rv_iommu_mmio_regs;

    localparam logic [63:0] CAPS_V = 64'hCAFE_0000_1234_5678;

    logic        clk, rst_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [63:0] pwdata;
`ifdef IOMMU_MMIO_WSTRB_EN
    logic [7:0]  pstrb;
`endif
    logic [63:0] prdata;
    logic        pready, pslverr;
    logic [3:0]  ddtp_mode_o;
    logic [43:0] ddtp_ppn_o;
    logic        ddtp_stall_req_o;
    logic        ddtp_pgwk_idle_i;
    logic [43:0] cq_ppn_o;
    logic [4:0]  cq_log2sz_o;
    logic        cq_on_o;
    logic [11:0] cq_head_o, cq_tail_o;
    logic        cq_head_inc_i, cq_mf_i, cq_ill_i;

    rv_iommu_mmio_regs #(.ADDR_W(12), .PPN_W(44), .CQ_IDX_W(12), .CAPS(CAPS_V)) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef IOMMU_MMIO_WSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .ddtp_mode_o(ddtp_mode_o), .ddtp_ppn_o(ddtp_ppn_o),
        .ddtp_stall_req_o(ddtp_stall_req_o), .ddtp_pgwk_idle_i(ddtp_pgwk_idle_i),
        .cq_ppn_o(cq_ppn_o), .cq_log2sz_o(cq_log2sz_o), .cq_on_o(cq_on_o),
        .cq_head_o(cq_head_o), .cq_tail_o(cq_tail_o),
        .cq_head_inc_i(cq_head_inc_i), .cq_mf_i(cq_mf_i), .cq_ill_i(cq_ill_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One APB transfer: setup phase, access phase (sampled mid-phase), then idle.
    // ill pulses cq_ill_i in the same cycle as the access phase.
    task automatic apb(input logic wr, input logic [11:0] a, input logic [63:0] d,
                       input logic ill, output logic [63:0] rd, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1; cq_ill_i = ill;
        #1;
        rd  = prdata;
        err = pslverr;
        chk($sformatf("pready@%0h", a), 64'(pready), 64'h1);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cq_ill_i = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic run_vec(input int i);
        logic [63:0] rd;
        logic        err;
        apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err);
        chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
        if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [63:0] exp);
        logic [63:0] rd;
        logic        err;
        apb(1'b0, a, 64'h0, 1'b0, rd, err);
        chk(nm, rd, exp);
    endtask

    task automatic wr_reg(input logic [11:0] a, input logic [63:0] d);
        logic [63:0] rd;
        logic        err;
        apb(1'b1, a, d, 1'b0, rd, err);
    endtask

    initial begin
        logic [63:0] rd;
        logic        err;

        // DDTP value 0x48C03 = ppn 0x123 << 10 | mode 3. CQB value 0x115800 = ppn 0x456 << 10.
        vecs[0]  = '{1'b0, 12'h000, 64'h0,        CAPS_V,       1'b0};
        vecs[1]  = '{1'b0, 12'h008, 64'h0,        64'h0,        1'b0};
        vecs[2]  = '{1'b0, 12'h030, 64'h0,        64'h0,        1'b1};
        vecs[3]  = '{1'b1, 12'h010, 64'h48C03,    64'h0,        1'b0};
        vecs[4]  = '{1'b0, 12'h010, 64'h0,        64'h48C13,    1'b0};
        vecs[5]  = '{1'b1, 12'h010, 64'h1DC02,    64'h0,        1'b0};  // write while busy
        vecs[6]  = '{1'b0, 12'h010, 64'h0,        64'h48C13,    1'b0};
        vecs[7]  = '{1'b1, 12'h010, 64'h1DC05,    64'h0,        1'b0};  // mode 5 rejected
        vecs[8]  = '{1'b0, 12'h010, 64'h0,        64'h48C03,    1'b0};
        vecs[9]  = '{1'b1, 12'h038, 64'h1,        64'h0,        1'b1};  // unmapped write
        vecs[10] = '{1'b0, 12'h048, 64'h0,        64'h0,        1'b0};
        vecs[11] = '{1'b1, 12'h018, 64'h11581F,   64'h0,        1'b0};  // log2sz 31 clamps to 11
        vecs[12] = '{1'b0, 12'h018, 64'h0,        64'h11580B,   1'b0};
        vecs[13] = '{1'b1, 12'h018, 64'h115802,   64'h0,        1'b0};
        vecs[14] = '{1'b0, 12'h018, 64'h0,        64'h115802,   1'b0};
        vecs[15] = '{1'b0, 12'h020, 64'h0,        64'h0,        1'b0};
        vecs[16] = '{1'b1, 12'h008, 64'hFFFF,     64'h0,        1'b0};  // RO write
        vecs[17] = '{1'b0, 12'h008, 64'h0,        64'h0,        1'b0};

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
`ifdef IOMMU_MMIO_WSTRB_EN
        pstrb = 8'hFF;
`endif
        ddtp_pgwk_idle_i = 1'b0; cq_head_inc_i = 1'b0; cq_mf_i = 1'b0; cq_ill_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prdata", prdata, 64'h0);
        chk("rst_pready", 64'(pready), 64'h0);
        chk("rst_pslverr", 64'(pslverr), 64'h0);
        chk("rst_mode", 64'(ddtp_mode_o), 64'h0);
        chk("rst_stall", 64'(ddtp_stall_req_o), 64'h0);
        chk("rst_cq_on", 64'(cq_on_o), 64'h0);
        chk("rst_head", 64'(cq_head_o), 64'h0);
        chk("rst_tail", 64'(cq_tail_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // DDTP write, and the writes that must be ignored while busy.
        for (int i = 0; i <= 6; i++) run_vec(i);
        chk("stall_busy", 64'(ddtp_stall_req_o), 64'h1);
        chk("shadow_hold_mode", 64'(ddtp_mode_o), 64'h0);
        chk("shadow_hold_ppn", 64'(ddtp_ppn_o), 64'h0);

        // Idle is raised 2 cycles later. The shadow takes the new value on the next edge.
        @(negedge clk);
        @(negedge clk);
        ddtp_pgwk_idle_i = 1'b1;
        #1;
        chk("stall_pre_edge", 64'(ddtp_stall_req_o), 64'h1);
        @(posedge clk);
        #1;
        chk("handover_mode", 64'(ddtp_mode_o), 64'h3);
        chk("handover_ppn", 64'(ddtp_ppn_o), 64'h123);
        chk("handover_busy", 64'(ddtp_stall_req_o), 64'h0);
        ddtp_pgwk_idle_i = 1'b0;

        for (int i = 7; i <= 17; i++) run_vec(i);
        chk("mode_after_bad", 64'(ddtp_mode_o), 64'h3);
        chk("cq_log2sz_o", 64'(cq_log2sz_o), 64'h2);
        chk("cq_ppn_o", 64'(cq_ppn_o), 64'h456);

        // Enable the CQ. Peek at CQCSR with back-to-back read access phases.
        wr_reg(12'h048, 64'h1);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h048;
        #1;
        chk("cqcsr_busy", prdata, 64'h20001);
        chk("cq_on_during_busy", 64'(cq_on_o), 64'h0);
        @(posedge clk);
        #1;
        chk("cqcsr_on", prdata, 64'h10001);
        chk("cq_on_after", 64'(cq_on_o), 64'h1);
        psel = 1'b0; penable = 1'b0;

        wr_reg(12'h018, 64'h3);
        rd_chk("cqb_locked", 12'h018, 64'h115802);

        // 9 head increments on an 8-entry queue wrap the head to 1.
        @(negedge clk);
        cq_head_inc_i = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        cq_head_inc_i = 1'b0;
        chk("head_wrap", 64'(cq_head_o), 64'h1);
        rd_chk("cqh_read", 12'h020, 64'h1);
        wr_reg(12'h020, 64'h0000_000B_0000_0000);
        rd_chk("cqt_mask", 12'h020, 64'h0000_0003_0000_0001);
        chk("tail_o", 64'(cq_tail_o), 64'h3);

        // cmd_ill set in the same cycle as its W1C. The set wins.
        apb(1'b1, 12'h048, 64'h401, 1'b1, rd, err);
        chk("ill_set_wins", 64'(cq_on_o), 64'h0);
        rd_chk("cqcsr_ill", 12'h048, 64'h10401);
        wr_reg(12'h048, 64'h401);
        rd_chk("cqcsr_ill_clr", 12'h048, 64'h10001);
        chk("cq_on_resume", 64'(cq_on_o), 64'h1);

        @(negedge clk);
        cq_mf_i = 1'b1;
        @(negedge clk);
        cq_mf_i = 1'b0;
        chk("mf_stall", 64'(cq_on_o), 64'h0);
        rd_chk("cqcsr_mf", 12'h048, 64'h10101);
        wr_reg(12'h048, 64'h101);
        chk("mf_clr", 64'(cq_on_o), 64'h1);

`ifdef IOMMU_MMIO_WSTRB_EN
        pstrb = 8'h02;
        wr_reg(12'h010, 64'h2404);
        rd_chk("strb_ignored", 12'h010, 64'h48C03);
        pstrb = 8'hFF;
        wr_reg(12'h010, 64'h2401);
        rd_chk("strb_accepted", 12'h010, 64'h2411);
`endif

        // Reset asserted in the middle of a DDTP write access.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 64'h1;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 64'(pready), 64'h0);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("midrst_mode", 64'(ddtp_mode_o), 64'h0);
        chk("midrst_cq_on", 64'(cq_on_o), 64'h0);
        chk("midrst_head", 64'(cq_head_o), 64'h0);
        chk("midrst_tail", 64'(cq_tail_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("midrst_ddtp", 12'h010, 64'h0);
        rd_chk("midrst_cqcsr", 12'h048, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
